// File: rtl/crossbar_pkg.sv
// Shared definitions for the two-master crossbar: arbiter state encoding,
// command values, timeout default and the slave-error signature.
package crossbar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RWAIT = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam logic [31:0] ERR_SIG_BASE           = 32'hDEAD_0000;
    localparam int          DEFAULT_TIMEOUT_CYCLES = 16;

    // Read data returned to a master whose transaction was aborted.
    function automatic logic [31:0] err_signature(input int unsigned num);
        return ERR_SIG_BASE | {16'h0000, num[15:0]};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin pick; on a tie the requester that was
// not granted last wins.
module rr_arb2 (
    input  logic req_0,
    input  logic req_1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_idx
);

    always_comb begin
        gnt_valid = req_0 | req_1;
        gnt_idx   = (req_0 & req_1) ? ~last : req_1;
    end

endmodule

// File: rtl/slave_arbiter.sv
// Per-slave arbiter for the two-master crossbar. Optional transaction
// timeout is built only when SLAVE_ARB_TIMEOUT_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | sample master requests, grant one round-robin
//   ST_ISSUE | slave req held with payload until ack_i
//   ST_RWAIT | read only: capture rdata_i
//   ST_DONE  | one-cycle ack (and read data) to the granted master
module slave_arbiter
    import crossbar_pkg::*;
#(
    parameter int NUM            = 0,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        master_0_req,
    input  logic        master_1_req,
    input  logic        master_0_cmd,
    input  logic        master_1_cmd,
    input  logic [31:0] master_0_addr,
    input  logic [31:0] master_1_addr,
    input  logic [31:0] master_0_wdata,
    input  logic [31:0] master_1_wdata,
    output logic        master_0_ack,
    output logic        master_1_ack,
    output logic [31:0] master_0_rdata,
    output logic [31:0] master_1_rdata,
    output logic        req,
    output logic        cmd,
    output logic [30:0] addr,
    output logic [31:0] wdata,
    input  logic        ack_i,
    input  logic [31:0] rdata_i,
    output logic        err
);

    if (NUM < 0 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("slave_arbiter: NUM must be >= 0 and TIMEOUT_CYCLES within 2..255");
    end

    arb_state_t  state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_q, gnt_d;
    logic        req_q, req_d;
    logic        cmd_q, cmd_d;
    logic [30:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        pick_valid;
    logic        pick_idx;
    logic        unused_addr_msb;

`ifdef SLAVE_ARB_TIMEOUT_EN
    localparam logic [31:0] ERR_SIG    = err_signature(NUM);
    localparam logic [7:0]  TIMER_LOAD = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] timer_q, timer_d;
    logic       abort_q, abort_d;
`endif

    rr_arb2 u_rr_arb2 (
        .req_0     (master_0_req),
        .req_1     (master_1_req),
        .last      (last_q),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        req_d   = req_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SLAVE_ARB_TIMEOUT_EN
        timer_d = timer_q;
        abort_d = abort_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick_idx;
                    last_d  = pick_idx;
                    req_d   = 1'b1;
                    cmd_d   = pick_idx ? master_1_cmd : master_0_cmd;
                    addr_d  = pick_idx ? master_1_addr[30:0] : master_0_addr[30:0];
                    wdata_d = pick_idx ? master_1_wdata : master_0_wdata;
                    state_d = ST_ISSUE;
`ifdef SLAVE_ARB_TIMEOUT_EN
                    timer_d = TIMER_LOAD;
`endif
                end
            end

            ST_ISSUE: begin
                // A slave ack in the expiry cycle still completes normally.
                if (ack_i) begin
                    req_d   = 1'b0;
                    cmd_d   = CMD_READ;
                    addr_d  = '0;
                    wdata_d = '0;
                    state_d = (cmd_q == CMD_WRITE) ? ST_DONE : ST_RWAIT;
                end
`ifdef SLAVE_ARB_TIMEOUT_EN
                else if (timer_q == 8'd0) begin
                    req_d   = 1'b0;
                    cmd_d   = CMD_READ;
                    addr_d  = '0;
                    wdata_d = '0;
                    rdata_d = ERR_SIG;
                    abort_d = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
`endif
            end

            ST_RWAIT: begin
                rdata_d = rdata_i;
                state_d = ST_DONE;
            end

            ST_DONE: begin
                rdata_d = '0;
                state_d = ST_IDLE;
`ifdef SLAVE_ARB_TIMEOUT_EN
                abort_d = 1'b0;
`endif
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            req_q   <= 1'b0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SLAVE_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q <= 8'd0;
            abort_q <= 1'b0;
        end else begin
            timer_q <= timer_d;
            abort_q <= abort_d;
        end
    end
`endif

    always_comb begin
        req            = req_q;
        cmd            = cmd_q;
        addr           = addr_q;
        wdata          = wdata_q;
        master_0_ack   = (state_q == ST_DONE) && (gnt_q == 1'b0);
        master_1_ack   = (state_q == ST_DONE) && (gnt_q == 1'b1);
        master_0_rdata = master_0_ack ? rdata_q : '0;
        master_1_rdata = master_1_ack ? rdata_q : '0;
`ifdef SLAVE_ARB_TIMEOUT_EN
        err            = abort_q;
`else
        err            = 1'b0;
`endif
        // Bit 31 only selected this slave upstream.
        unused_addr_msb = master_0_addr[31] ^ master_1_addr[31];
    end

endmodule

// File: doc/slave_arbiter.md
# slave_arbiter

Per-slave arbiter for the two-master, 32-bit crossbar. It accepts already-decoded requests from master 0 and master 1 and grants exactly one at a time using round-robin. It drives the granted request onto the slave port, holds it until the slave acknowledges, then routes the ack and read data back to the winning master only. One instance sits in front of each slave and resolves the simultaneous-request case.

## Interface
- `NUM`, 0 — slave index; informational, used in the slave-error signature.
- `TIMEOUT_CYCLES`, 16 — max cycles in ISSUE/RWAIT before abort; range 2..255; used only with the timeout macro.
- `clk` in 1 — single clock; all logic on the rising edge.
- `rst` in 1 — synchronous reset, active-high.
- `master_0_req`, `master_1_req` in 1 each — request, already decoded for this slave; held high until the master sees its ack.
- `master_0_cmd`, `master_1_cmd` in 1 each — 1 = write, 0 = read.
- `master_0_addr`, `master_1_addr` in 32 each — bits [30:0] forwarded; bit 31 is the slave select and is dropped.
- `master_0_wdata`, `master_1_wdata` in 32 each — write data.
- `master_0_ack`, `master_1_ack` out 1 each — one-cycle completion pulse.
- `master_0_rdata`, `master_1_rdata` out 32 each — read data, valid only in the ack cycle; 0 otherwise.
- `req` out 1 — slave request.
- `cmd` out 1 — slave command.
- `addr` out 31 — slave address.
- `wdata` out 32 — slave write data.
- `ack_i` in 1 — slave accept pulse.
- `rdata_i` in 32 — slave read data, valid exactly one cycle after `ack_i`.
- `err` out 1 — one-cycle pulse when a transaction is aborted by timeout.

## Operation
- Reset value of all outputs is 0. Reset puts the FSM in IDLE, sets `last` to 1 so master 0 wins the first tie, and clears the timer. Reset mid-transaction abandons it with no ack issued.
- **IDLE**
  - Sample `{master_1_req, master_0_req}`.
    - 01 grants master 0.
    - 10 grants master 1.
    - 11 grants the master that is not `last`.
    - 00 stays in IDLE.
  - On a grant: register `cmd`/`addr[30:0]`/`wdata` from the winner, set `req`=1, update `last`, go to ISSUE.
- **ISSUE**
  - `req` and the payload are held stable.
  - On `ack_i`=1: drop `req` and clear `addr`/`wdata`/`cmd` to 0.
    - Write: go to DONE.
    - Read: go to RWAIT.
  - Master requests are ignored; a change of the granted master's `req` does not cancel the transaction.
- **RWAIT** — one cycle. Capture `rdata_i` into the return register, go to DONE.
- **DONE**
  - Pulse `master_<g>_ack`=1 for one cycle.
  - For reads, drive the captured data on `master_<g>_rdata`.
  - The other master's ack and rdata stay 0.
  - Next state is IDLE.
- Round-robin fairness: with both requesting continuously, grants alternate 0,1,0,1…
- `ack_i` outside ISSUE is ignored.

## Timing
- Request sampled at edge N, so `req`=1 is visible from N+1.
- Write: `ack_i` high in cycle M gives `master_<g>_ack` in cycle M+1.
- Read: `ack_i` in cycle M, `rdata_i` sampled at the end of M+1, so `master_<g>_ack` and `master_<g>_rdata` appear in cycle M+2.
- Minimum transaction, with `ack_i` the cycle after `req` rises: write is 4 cycles IDLE→IDLE, read is 5.
- The master drops `req` on the edge ending DONE; IDLE then samples fresh requests, so a completed request is never re-granted.
- Back-to-back throughput: one transaction per 4 (write) or 5 (read) cycles.

## Configuration
- **With `SLAVE_ARB_TIMEOUT_EN` defined:**
  - An 8-bit timer counts cycles spent in ISSUE/RWAIT and resets on each grant.
  - When it reaches `TIMEOUT_CYCLES` without `ack_i`: drop `req`, go to DONE, ack the granted master with rdata = 32'hDEAD_0000 | `NUM`[15:0], and pulse `err` in the same DONE cycle.
  - An `ack_i` arriving in the same cycle as expiry takes precedence: normal completion, no `err`.
- **Without the macro:** the FSM waits indefinitely in ISSUE, no timer is built, and `err` is tied to 0.

## Structure
- Shared package `crossbar_pkg`:
  - FSM state encoding: IDLE, ISSUE, RWAIT, DONE.
  - `CMD_READ`=0, `CMD_WRITE`=1.
  - Error signature base 32'hDEAD_0000.
  - Default `TIMEOUT_CYCLES`.
- Sub-module `rr_arb2`: combinational 2-way round-robin pick. Inputs are the two request bits and `last`; outputs are `gnt_valid` and `gnt_idx`. It is reusable by the other slaves' instances.

## Test plan
- Master 0 write only: addr 0x8000_0010, wdata 0xA5A5_A5A5, `ack_i` 2 cycles after `req`. Expect slave addr 0x0000_0010, `master_0_ack` one cycle after `ack_i`, `master_1_ack` never.
- Master 1 read: slave returns `ack_i`, then `rdata_i`=0x1234_5678. Expect `master_1_rdata`=0x1234_5678 with `master_1_ack` 2 cycles after `ack_i`; `master_0_rdata` stays 0.
- Both masters request in the same cycle directly after reset. Expect master 0 granted first, then master 1 with no idle gap beyond IDLE; with continuous requests, 4 grants alternate 0,1,0,1.
- Assert `rst` during ISSUE. Expect `req`=0 and all acks 0 on the next cycle; after release, a new request from master 0 is granted normally.
- Timeout with `SLAVE_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `NUM`=3, `ack_i` held 0. Expect `req` to drop, `master_0_ack`=1 with rdata 0xDEAD_0003, and `err` pulse one cycle. Without the macro, `req` stays high for 100 cycles.
